mod_n_step_counter: RTL and testbench
=====================================

// Module: mod_n_step_counter
// PURPOSE
//  Parametrised modulo-N up/down state counter stepped by a debounced push-button edge.
//  Successor to the 3-bit button-stepped state machine on the EGO1 board:
//  - fully synchronous to the board clock; the button is never used as a clock
//  - N-bit count with selectable modulus, direction and step edge
//  - synchronous load
//  - wrap flag plus carry/borrow pulses
//  Sits between the EGO1 button pins and the LED/segment display logic.
// PARAMETERS
//  WIDTH          3        count width in bits; 1..16
//  MODULUS        8        count sequence length; 2..2**WIDTH
//  DEBOUNCE_CYC   2000000  cycles the button level must stay stable to be accepted (20 ms @ 100 MHz); >=1
//  STEP_ON_PRESS  0        0: step on button release (falling edge); 1: step on press (rising edge)
// PORTS
//  sys_clk_in   in   1      board clock; all state on rising edge
//  sys_rst_n    in   1      asynchronous active-low reset
//  btn_step     in   1      raw button, active-high, asynchronous to the clock
//  up_dn        in   1      1 = count up, 0 = count down; sampled together with the step pulse
//  load         in   1      synchronous load strobe
//  load_val     in   WIDTH  value to load
//  count        out  WIDTH  current state
//  z            out  1      wrap flag; high from a wrapping step until the next step or load
//  carry        out  1      one-cycle pulse on an up-wrap
//  borrow       out  1      one-cycle pulse on a down-wrap
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - count=0, z=0, carry=0, borrow=0
//   - both synchroniser flops=0, debounced level=0, debounce counter=0
//  Input path:
//   - btn_step passes through a 2-flop synchroniser (btn_s)
//   - debounce counter clears whenever btn_s equals the debounced level; otherwise it increments
//   - when the counter reaches DEBOUNCE_CYC-1 while btn_s still differs, the debounced level takes btn_s
//     and the counter clears
//   - any bounce back to the old level before that point clears the counter; the level does not change
//  Step pulse:
//   - one cycle, registered
//   - fires the cycle after the debounced level makes the selected transition (0->1 or 1->0)
//  Latency:
//   - raw edge sampled at clock edge T -> count changes at edge T+DEBOUNCE_CYC+3
//   - load_val sampled at edge T appears on count after edge T (1 cycle)
//  Count update, priority load > step > hold:
//   - load: count = (load_val >= MODULUS) ? MODULUS-1 : load_val; z=0; no pulse
//   - step, up_dn=1: count==MODULUS-1 -> count=0, z=1, carry=1; else count+1, z=0
//   - step, up_dn=0: count==0 -> count=MODULUS-1, z=1, borrow=1; else count-1, z=0
//   - hold: count and z unchanged; carry=borrow=0
//   - load and step in the same cycle: the load wins and the step is dropped (not queued)
//  Arithmetic:
//   - WIDTH-bit unsigned; count never leaves 0..MODULUS-1
//   - when MODULUS==2**WIDTH, wrap equals natural overflow but carry/borrow still fire
//  Constraints:
//   - carry and borrow are never both high
//   - z is high only in the cycle of, or after, a carry/borrow
//  Reset mid-operation:
//   - everything returns to the reset values immediately
//   - a button held through reset release produces no step until it is released and re-pressed
//     as a debounced transition
//  Illegal parameters (MODULUS<2, MODULUS>2**WIDTH, DEBOUNCE_CYC<1) -> simulation $error at time 0.
// TESTING (bench: DEBOUNCE_CYC=4, WIDTH=3, MODULUS=8 unless noted)
//  1 Reset, then 8 clean press/release cycles, up_dn=1, STEP_ON_PRESS=0
//    -> count 1..7 then 0; z=1 and carry pulse only on the 7->0 step.
//  2 Bounce: toggle btn_step every 2 cycles for 20 cycles, then hold 1 for 10 cycles
//    -> exactly one debounced rise; no step until the release is debounced; count +1 total.
//  3 Down from reset with up_dn=0, one step
//    -> count=7, z=1, borrow=1 for one cycle.
//    Next step -> count=6, z=0.
//  4 load=1, load_val=5 in the same cycle as a step pulse
//    -> count=5, z=0, no carry.
//  5 MODULUS=6: load_val=7 -> count=5; one up step -> count=0 with carry.
//  6 Assert sys_rst_n=0 mid-debounce with count=3
//    -> count=0 immediately.
//    Button held through reset release -> no step until release and re-press.
//  Check latency: raw edge to count change = DEBOUNCE_CYC+3 = 7 cycles.

Source files
------------

// File: rtl/mod_n_step_counter.sv
// mod_n_step_counter: modulo-N up/down counter stepped by a synchronised, debounced push-button edge,
// with synchronous load, sticky wrap flag and one-cycle carry/borrow pulses.
module mod_n_step_counter #(
    parameter int WIDTH         = 3,
    parameter int MODULUS       = 8,
    parameter int DEBOUNCE_CYC  = 2000000,
    parameter bit STEP_ON_PRESS = 1'b0
) (
    input  logic             sys_clk_in,
    input  logic             sys_rst_n,
    input  logic             btn_step,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             z,
    output logic             carry,
    output logic             borrow
);
    localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYC - 1);

    if (MODULUS < 2 || MODULUS > 2**WIDTH || DEBOUNCE_CYC < 1) begin : g_bad_params
        $error("mod_n_step_counter: illegal parameters WIDTH=%0d MODULUS=%0d DEBOUNCE_CYC=%0d",
               WIDTH, MODULUS, DEBOUNCE_CYC);
    end

    logic [1:0]       sync_q, fill_q, fill_d;
    logic             level_q, level_d, level_prev_q;
    logic [CW-1:0]    db_cnt_q, db_cnt_d;
    logic             armed_q, armed_d, press_ok_q, press_ok_d;
    logic             step_q, step_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             z_q, z_d, carry_q, carry_d, borrow_q, borrow_d;
    logic             btn_s, rise, fall, wrap_up, wrap_dn;

    // A press only counts once the synchroniser has shown the button low after reset,
    // so a button held through reset never produces a step on its own release.
    always_comb begin
        btn_s      = sync_q[1];
        level_d    = level_q;
        db_cnt_d   = '0;
        if (btn_s != level_q) begin
            if (db_cnt_q == DB_LAST) level_d = btn_s;
            else db_cnt_d = db_cnt_q + 1'b1;
        end
        rise       = level_q & ~level_prev_q;
        fall       = ~level_q & level_prev_q;
        fill_d     = fill_q[1] ? fill_q : fill_q + 2'd1;
        armed_d    = armed_q | (fill_q[1] & ~btn_s);
        press_ok_d = rise ? armed_q : press_ok_q;
        step_d     = STEP_ON_PRESS ? (rise & armed_q) : (fall & press_ok_q);
        wrap_up    = count_q == MAX;
        wrap_dn    = count_q == '0;
        count_d    = count_q;
        z_d        = z_q;
        carry_d    = 1'b0;
        borrow_d   = 1'b0;
        if (load) begin
            count_d = (32'(load_val) >= MODULUS) ? MAX : load_val;
            z_d     = 1'b0;
        end else if (step_q) begin
            count_d  = up_dn ? (wrap_up ? '0 : count_q + 1'b1) : (wrap_dn ? MAX : count_q - 1'b1);
            z_d      = up_dn ? wrap_up : wrap_dn;
            carry_d  = up_dn & wrap_up;
            borrow_d = ~up_dn & wrap_dn;
        end
    end

    always_ff @(posedge sys_clk_in or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_q       <= '0;
            fill_q       <= '0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            db_cnt_q     <= '0;
            armed_q      <= 1'b0;
            press_ok_q   <= 1'b0;
            step_q       <= 1'b0;
            count_q      <= '0;
            z_q          <= 1'b0;
            carry_q      <= 1'b0;
            borrow_q     <= 1'b0;
        end else begin
            sync_q       <= {sync_q[0], btn_step};
            fill_q       <= fill_d;
            level_q      <= level_d;
            level_prev_q <= level_q;
            db_cnt_q     <= db_cnt_d;
            armed_q      <= armed_d;
            press_ok_q   <= press_ok_d;
            step_q       <= step_d;
            count_q      <= count_d;
            z_q          <= z_d;
            carry_q      <= carry_d;
            borrow_q     <= borrow_d;
        end
    end

    assign count  = count_q;
    assign z      = z_q;
    assign carry  = carry_q;
    assign borrow = borrow_q;
endmodule

// File: tb/tb_mod_n_step_counter.sv
// tb_mod_n_step_counter: directed checks of a modulo-8 and a modulo-6 instance sharing one stimulus.
module tb_mod_n_step_counter;
    logic       clk = 1'b0;
    logic       rst_n, btn, up_dn, load;
    logic [2:0] load_val, count, count6;
    logic       z, carry, borrow, z6, carry6, borrow6;
    int         tests = 0, fails = 0;

    always #5 clk = ~clk;

    mod_n_step_counter #(.WIDTH(3), .MODULUS(8), .DEBOUNCE_CYC(4), .STEP_ON_PRESS(1'b0)) dut (
        .sys_clk_in(clk), .sys_rst_n(rst_n), .btn_step(btn), .up_dn(up_dn), .load(load),
        .load_val(load_val), .count(count), .z(z), .carry(carry), .borrow(borrow));

    mod_n_step_counter #(.WIDTH(3), .MODULUS(6), .DEBOUNCE_CYC(4), .STEP_ON_PRESS(1'b0)) dut6 (
        .sys_clk_in(clk), .sys_rst_n(rst_n), .btn_step(btn), .up_dn(up_dn), .load(load),
        .load_val(load_val), .count(count6), .z(z6), .carry(carry6), .borrow(borrow6));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Press, release, and stop on the cycle where the release-driven step becomes visible.
    task automatic press_step();
        btn = 1'b1;
        tick(10);
        btn = 1'b0;
        tick(8);
    endtask

    initial begin
        rst_n = 1'b0; btn = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = '0;
        tick(3);
        chk("reset_count", count, 0);
        chk("reset_z", z, 0);
        chk("reset_carry", carry, 0);
        chk("reset_borrow", borrow, 0);
        rst_n = 1'b1;
        tick(3);

        for (int i = 1; i <= 8; i++) begin
            btn = 1'b1;
            tick(10);
            btn = 1'b0;
            tick(7);
            chk("t1_latency_hold", count, i - 1);
            tick(1);
            chk("t1_count", count, i % 8);
            chk("t1_carry", carry, i == 8);
            chk("t1_z", z, i == 8);
            tick(1);
            chk("t1_carry_pulse_end", carry, 0);
            tick(2);
        end

        for (int k = 0; k < 10; k++) begin
            btn = (k % 2 == 0);
            tick(2);
        end
        chk("t2_bounce_no_step", count, 0);
        btn = 1'b1;
        tick(10);
        chk("t2_press_no_step", count, 0);
        chk("t2_z_kept", z, 1);
        btn = 1'b0;
        tick(7);
        chk("t2_release_hold", count, 0);
        tick(1);
        chk("t2_count", count, 1);
        chk("t2_z", z, 0);
        chk("t2_carry", carry, 0);
        tick(3);

        rst_n = 1'b0; up_dn = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(3);
        press_step();
        chk("t3_count", count, 7);
        chk("t3_z", z, 1);
        chk("t3_borrow", borrow, 1);
        chk("t3_carry", carry, 0);
        chk("t3_m6_count", count6, 5);
        tick(1);
        chk("t3_borrow_end", borrow, 0);
        chk("t3_z_kept", z, 1);
        press_step();
        chk("t3_count2", count, 6);
        chk("t3_z2", z, 0);
        tick(3);

        up_dn = 1'b1; load = 1'b1; load_val = 3'd7;
        tick(1);
        load = 1'b0;
        chk("t4_load7", count, 7);
        chk("t5_m6_clamp", count6, 5);
        btn = 1'b1;
        tick(10);
        btn = 1'b0;
        tick(7);
        load = 1'b1; load_val = 3'd5;
        tick(1);
        load = 1'b0;
        chk("t4_load_wins", count, 5);
        chk("t4_z", z, 0);
        chk("t4_carry", carry, 0);
        tick(3);
        chk("t4_step_dropped", count, 5);

        press_step();
        chk("t5_m6_wrap", count6, 0);
        chk("t5_m6_carry", carry6, 1);
        chk("t5_m6_z", z6, 1);
        chk("t5_m8_count", count, 6);
        chk("t5_m8_carry", carry, 0);
        tick(3);

        load = 1'b1; load_val = 3'd3;
        tick(1);
        load = 1'b0;
        chk("t6_load3", count, 3);
        btn = 1'b1;
        tick(2);
        rst_n = 1'b0;
        #1;
        chk("t6_async_reset", count, 0);
        chk("t6_async_reset_m6", count6, 0);
        tick(3);
        rst_n = 1'b1;
        tick(20);
        chk("t6_held_no_step", count, 0);
        btn = 1'b0;
        tick(20);
        chk("t6_release_no_step", count, 0);
        press_step();
        chk("t6_repress_step", count, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
